// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop line synchroniser, frame FSM with optional
// parity and 1/2 stop bits, and a first-word-fall-through receive FIFO.
//
// state    | meaning
// S_IDLE   | line idle, waiting for a synced low
// S_START  | half-bit wait, confirm start bit still low
// S_DATA   | sample DATA_BITS data bits, LSB first
// S_PARITY | sample parity bit (PARITY_MODE != 0 only)
// S_STOP   | sample stop bit(s), push frame on the last one
// S_BREAK  | last stop bit was low, wait for line to return high
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset_n,
  input  logic                 i_Rx_Serial,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Rx_Parity_Err,
  output logic                 o_Rx_Frame_Err,
  output logic                 o_Rx_Valid,
  input  logic                 i_Rx_Ready,
  output logic                 o_Overrun,
  input  logic                 i_Clear_Overrun,
  output logic                 o_Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = DATA_BITS + 2;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] IDX_DLAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_SLAST = IDX_W'(STOP_BITS - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  logic                 rx_meta, rx_sync;
  state_t               state, state_nxt;
  logic [CNT_W-1:0]     clk_cnt, cnt_nxt;
  logic [IDX_W-1:0]     bit_idx, idx_nxt;
  logic [DATA_BITS-1:0] data_sr, data_nxt;
  logic                 par_err, par_nxt;
  logic                 frm_err, frm_nxt;
  logic                 par_calc;
  logic                 push;
  logic                 push_frm;

  logic [ENT_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       fifo_cnt;
  logic                 fifo_full;
  logic                 do_push, do_pop, ovr_set;
  logic [ENT_W-1:0]     head;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      data_sr <= '0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= cnt_nxt;
      bit_idx <= idx_nxt;
      data_sr <= data_nxt;
      par_err <= par_nxt;
      frm_err <= frm_nxt;
    end
  end

  // Odd parity flags an even total, even parity flags an odd total.
  assign par_calc = ^{data_sr, rx_sync};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = clk_cnt;
    idx_nxt   = bit_idx;
    data_nxt  = data_sr;
    par_nxt   = par_err;
    frm_nxt   = frm_err;
    push      = 1'b0;
    push_frm  = frm_err | ~rx_sync;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (!rx_sync) begin
          state_nxt = S_START;
          par_nxt   = 1'b0;
          frm_nxt   = 1'b0;
        end
      end
      S_START: begin
        if (clk_cnt == CNT_HALF) begin
          cnt_nxt   = '0;
          state_nxt = rx_sync ? S_IDLE : S_DATA;
        end else begin
          cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (clk_cnt == CNT_LAST) begin
          cnt_nxt  = '0;
          data_nxt = {rx_sync, data_sr[DATA_BITS-1:1]};
          if (bit_idx == IDX_DLAST) begin
            idx_nxt   = '0;
            state_nxt = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_nxt = bit_idx + IDX_W'(1);
          end
        end else begin
          cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (clk_cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          par_nxt   = (PARITY_MODE == 1) ? ~par_calc : par_calc;
          state_nxt = S_STOP;
        end else begin
          cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (clk_cnt == CNT_LAST) begin
          cnt_nxt = '0;
          frm_nxt = push_frm;
          if (bit_idx == IDX_SLAST) begin
            idx_nxt   = '0;
            push      = 1'b1;
            state_nxt = rx_sync ? S_IDLE : S_BREAK;
          end else begin
            idx_nxt = bit_idx + IDX_W'(1);
          end
        end else begin
          cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      S_BREAK: begin
        cnt_nxt = '0;
        if (rx_sync) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign fifo_full = (fifo_cnt == FIFO_FULL);
  assign do_pop    = o_Rx_Valid & i_Rx_Ready;
  assign do_push   = push & (~fifo_full | do_pop);
  assign ovr_set   = push & fifo_full & ~do_pop;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      o_Overrun <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= {push_frm, par_err, data_sr};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      // A new overrun takes priority over a coincident clear.
      if (ovr_set)              o_Overrun <= 1'b1;
      else if (i_Clear_Overrun) o_Overrun <= 1'b0;
    end
  end

  assign head            = mem[rd_ptr];
  assign o_Rx_Data       = head[DATA_BITS-1:0];
  assign o_Rx_Parity_Err = head[DATA_BITS];
  assign o_Rx_Frame_Err  = head[DATA_BITS+1];
  assign o_Rx_Valid      = (fifo_cnt != '0);
  assign o_Busy          = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: instance a is 8N1, instance b is 8E2; directed
// corner cases, a vector table on b, then random frames against a queue model.
module tb_uart_rx_param;
  localparam int CPB = 8;

  logic clk;
  logic rst_n;
  logic rx_a, rx_b, rdy_a, rdy_b, clr_a, clr_b;
  logic [7:0] data_a, data_b;
  logic perr_a, ferr_a, valid_a, ovr_a, busy_a;
  logic perr_b, ferr_b, valid_b, ovr_b, busy_b;

  int n_checks;
  int n_fail;
  bit sb_en;
  bit rand_rdy;
  logic [9:0] q_a[$];
  logic [9:0] q_b[$];

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       s1;
    logic       s2;
    logic [7:0] exp_d;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_a (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(rx_a),
    .o_Rx_Data(data_a), .o_Rx_Parity_Err(perr_a), .o_Rx_Frame_Err(ferr_a),
    .o_Rx_Valid(valid_a), .i_Rx_Ready(rdy_a), .o_Overrun(ovr_a),
    .i_Clear_Overrun(clr_a), .o_Busy(busy_a)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut_b (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(rx_b),
    .o_Rx_Data(data_b), .o_Rx_Parity_Err(perr_b), .o_Rx_Frame_Err(ferr_b),
    .o_Rx_Valid(valid_b), .i_Rx_Ready(rdy_b), .o_Overrun(ovr_b),
    .i_Clear_Overrun(clr_b), .o_Busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic sb_pop(input int which);
    logic [9:0] got;
    logic [9:0] e;
    got = (which == 0) ? {ferr_a, perr_a, data_a} : {ferr_b, perr_b, data_b};
    if ((which == 0 && q_a.size() == 0) || (which == 1 && q_b.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_extra_%0d: got entry 0x%0h, expected none", which, got);
    end else begin
      e = (which == 0) ? q_a.pop_front() : q_b.pop_front();
      check(which == 0 ? "sb_entry_a" : "sb_entry_b", {22'd0, got}, {22'd0, e});
    end
  endtask

  // One clock step; handshakes due on the coming edge are scored first.
  task automatic tick();
    if (sb_en) begin
      if (valid_a && rdy_a) sb_pop(0);
      if (valid_b && rdy_b) sb_pop(1);
    end
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      rdy_a = ($urandom_range(0, 3) != 0);
      rdy_b = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx_a = v;
    else            rx_b = v;
  endtask

  task automatic drive_bit(input int which, input logic v);
    set_line(which, v);
    repeat (CPB) tick();
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input bit use_par,
                            input logic par, input logic s1, input logic s2, input int nstop);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    if (use_par) drive_bit(which, par);
    drive_bit(which, s1);
    if (nstop == 2) drive_bit(which, s2);
  endtask

  task automatic wait_valid(input int which, input int max_cyc, input string name);
    int n;
    n = 0;
    while (!((which == 0) ? valid_a : valid_b) && n < max_cyc) begin
      tick();
      n++;
    end
    check(name, (which == 0) ? valid_a : valid_b, 1);
  endtask

  task automatic pop_one(input int which);
    if (which == 0) rdy_a = 1'b1;
    else            rdy_b = 1'b1;
    tick();
    rdy_a = 1'b0;
    rdy_b = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       par, s1, s2;
    int         which, n;
    bit         seen_busy;

    n_checks = 0;
    n_fail   = 0;
    sb_en    = 1'b0;
    rand_rdy = 1'b0;
    rst_n = 1'b0;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    clr_a = 1'b0;
    clr_b = 1'b0;

    vecs[0] = '{8'h03, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
    vecs[1] = '{8'h03, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1};
    vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{8'h7E, 1'b0, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1};

    #1;
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_data", data_a, 0);
    check("rst_overrun", ovr_a, 0);
    check("rst_errs", {perr_a, ferr_a}, 0);
    check("rst_b_outs", {valid_b, busy_b, ovr_b, data_b}, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // 8N1 basic frame and handshake
    send_frame(0, 8'hA5, 0, 1'b0, 1'b1, 1'b1, 1);
    check("t1_valid_80clk", valid_a, 1);
    check("t1_data", data_a, 8'hA5);
    check("t1_errs", {perr_a, ferr_a}, 0);
    pop_one(0);
    check("t1_valid_after_pop", valid_a, 0);
    drive_bit(0, 1'b1);

    // short glitch on idle line
    set_line(0, 1'b0);
    repeat (2) tick();
    set_line(0, 1'b1);
    seen_busy = 1'b0;
    n = 0;
    while (!(seen_busy && !busy_a) && n < 6) begin
      tick();
      if (busy_a) seen_busy = 1'b1;
      n++;
    end
    check("t4_busy_seen", seen_busy, 1);
    check("t4_busy_idle", busy_a, 0);
    repeat (20) tick();
    check("t4_no_entry", valid_a, 0);

    // framing error followed by a long break
    send_frame(0, 8'h55, 0, 1'b0, 1'b0, 1'b1, 1);
    repeat (30) drive_bit(0, 1'b0);
    check("t3_busy_in_break", busy_a, 1);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    check("t3_valid", valid_a, 1);
    check("t3_data", data_a, 8'h55);
    check("t3_ferr", ferr_a, 1);
    check("t3_perr", perr_a, 0);
    pop_one(0);
    check("t3_one_entry", valid_a, 0);
    send_frame(0, 8'h3C, 0, 1'b0, 1'b1, 1'b1, 1);
    drive_bit(0, 1'b1);
    wait_valid(0, 20, "t3_next_valid");
    check("t3_next_entry", {ferr_a, perr_a, data_a}, {2'b00, 8'h3C});
    pop_one(0);

    // overrun with consumer stalled
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) check("t5_no_ovr_at_4", ovr_a, 0);
      send_frame(0, 8'(i), 0, 1'b0, 1'b1, 1'b1, 1);
      drive_bit(0, 1'b1);
    end
    check("t5_overrun", ovr_a, 1);
    check("t5_head", data_a, 8'h01);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    check("t5_ovr_cleared", ovr_a, 0);
    for (int i = 1; i <= 4; i++) begin
      check("t5_drain_valid", valid_a, 1);
      check("t5_drain_data", data_a, i);
      pop_one(0);
    end
    check("t5_empty", valid_a, 0);

    // even parity, two stop bits: vector table
    for (int v = 0; v < 8; v++) begin
      send_frame(1, vecs[v].d, 1, vecs[v].par, vecs[v].s1, vecs[v].s2, 2);
      drive_bit(1, 1'b1);
      wait_valid(1, 20, "tbl_valid");
      check("tbl_data", data_b, vecs[v].exp_d);
      check("tbl_perr", perr_b, vecs[v].exp_perr);
      check("tbl_ferr", ferr_b, vecs[v].exp_ferr);
      pop_one(1);
      check("tbl_single", valid_b, 0);
    end

    // reset during data bit 3, with an entry already buffered
    send_frame(0, 8'h11, 0, 1'b0, 1'b1, 1'b1, 1);
    drive_bit(0, 1'b1);
    check("t6_buffered", valid_a, 1);
    d = 8'h5A;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, d[i]);
    set_line(0, d[3]);
    repeat (3) tick();
    check("t6_busy_mid", busy_a, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy_a, 0);
    check("t6_rst_valid", valid_a, 0);
    check("t6_rst_data_ovr", {ovr_a, data_a}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    set_line(0, 1'b1);
    repeat (16) tick();
    check("t6_no_partial", valid_a, 0);
    send_frame(0, 8'hC3, 0, 1'b0, 1'b1, 1'b1, 1);
    drive_bit(0, 1'b1);
    wait_valid(0, 20, "t6_valid");
    check("t6_entry", {ferr_a, perr_a, data_a}, {2'b00, 8'hC3});
    pop_one(0);

    // random frames scored against the queue model
    sb_en    = 1'b1;
    rand_rdy = 1'b1;
    for (int k = 0; k < 24; k++) begin
      which = k % 2;
      d   = 8'($urandom);
      par = 1'($urandom);
      s1  = ($urandom_range(0, 4) != 0);
      s2  = ($urandom_range(0, 4) != 0);
      if (which == 0) begin
        q_a.push_back({~s1, 1'b0, d});
        send_frame(0, d, 0, 1'b0, s1, 1'b1, 1);
        drive_bit(0, 1'b1);
      end else begin
        q_b.push_back({~(s1 & s2), (($countones(d) + int'(par)) % 2) != 0, d});
        send_frame(1, d, 1, par, s1, s2, 2);
        drive_bit(1, 1'b1);
      end
    end
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    rand_rdy = 1'b0;
    sb_en    = 1'b0;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    tick();
    check("rand_queue_a_empty", q_a.size(), 0);
    check("rand_queue_b_empty", q_b.size(), 0);
    check("rand_fifos_empty", {valid_a, valid_b}, 0);
    check("rand_no_overrun", {ovr_a, ovr_b}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
